// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / mul-div sequencing control.
package hazard_pkg;

    typedef enum logic {HZ_IDLE, HZ_RUN} hz_state_t;

    localparam logic MD_KIND_MUL = 1'b0;
    localparam logic MD_KIND_DIV = 1'b1;

endpackage

// File: rtl/hazard_md_timer.sv
// Mul/div occupancy timer: loads a remaining-cycle count, decrements while running, flags zero.
module hazard_md_timer
    import hazard_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use detection, mul/div issue/busy/HI-LO interlock, branch flush.
// Optional stall-cycle counter enabled by defining HAZARD_STALLCNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_MUL_CYC = 4,
    parameter int MD_DIV_CYC = 32,
    parameter int REG_AW     = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_addr_Drs,
    input  logic [REG_AW-1:0] i_addr_Drt,
    input  logic              i_con_Dusesrs,
    input  logic              i_con_Dusesrt,
    input  logic [REG_AW-1:0] i_addr_Eregdst,
    input  logic              i_con_Ememread,
    input  logic              i_con_Dmdstart,
    input  logic              i_con_Dmdkind,
    input  logic              i_con_Dmdread,
    input  logic              i_con_Ebranchtaken,
    output logic              o_con_Fstall,
    output logic              o_con_Dstall,
    output logic              o_con_Dflush,
    output logic              o_con_Eflush,
    output logic              o_con_mdstart,
    output logic              o_con_mdbusy,
    output logic [31:0]       o_data_stallcnt
);

    localparam int CW = (MD_DIV_CYC > 1) ? $clog2(MD_DIV_CYC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MD_MUL_CYC - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(MD_DIV_CYC - 1);

    hz_state_t r_state;
    hz_state_t w_state_nxt;
    logic      w_lu;
    logic      w_mdh;
    logic      w_issue;
    logic      w_zero;
    logic      w_stall;

    assign w_lu = i_con_Ememread && (i_addr_Eregdst != '0) &&
                  ((i_con_Dusesrs && (i_addr_Drs == i_addr_Eregdst)) ||
                   (i_con_Dusesrt && (i_addr_Drt == i_addr_Eregdst)));

    assign w_mdh   = (r_state == HZ_RUN) && (i_con_Dmdread || i_con_Dmdstart);
    assign w_issue = (r_state == HZ_IDLE) && i_con_Dmdstart && !i_con_Ebranchtaken && !w_lu;

    hazard_md_timer #(.CW(CW)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_issue),
        .i_load_val ((i_con_Dmdkind == MD_KIND_DIV) ? DIV_LOAD : MUL_LOAD),
        .i_dec      (r_state == HZ_RUN),
        .o_zero     (w_zero)
    );

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HZ_IDLE: if (w_issue) w_state_nxt = HZ_RUN;
            HZ_RUN:  if (w_zero)  w_state_nxt = HZ_IDLE;
            default: w_state_nxt = HZ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= HZ_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Branch outranks both stalls; outputs are forced low while reset is asserted.
    assign w_stall       = !i_con_Ebranchtaken && (w_lu || w_mdh);
    assign o_con_Fstall  = !i_rst && w_stall;
    assign o_con_Dstall  = !i_rst && w_stall;
    assign o_con_Dflush  = !i_rst && i_con_Ebranchtaken;
    assign o_con_Eflush  = !i_rst && (i_con_Ebranchtaken || w_lu || w_mdh);
    assign o_con_mdstart = !i_rst && w_issue;
    assign o_con_mdbusy  = !i_rst && (r_state == HZ_RUN);

`ifdef HAZARD_STALLCNT_EN
    logic [31:0] r_stallcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stallcnt <= '0;
        end else if (o_con_Fstall && (r_stallcnt != 32'hFFFF_FFFF)) begin
            r_stallcnt <= r_stallcnt + 32'd1;
        end
    end

    assign o_data_stallcnt = r_stallcnt;
`else
    assign o_data_stallcnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazards, sequences for mul/div and reset.
module tb_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  i_addr_Drs, i_addr_Drt, i_addr_Eregdst;
    logic        i_con_Dusesrs, i_con_Dusesrt, i_con_Ememread;
    logic        i_con_Dmdstart, i_con_Dmdkind, i_con_Dmdread, i_con_Ebranchtaken;
    logic        o_con_Fstall, o_con_Dstall, o_con_Dflush, o_con_Eflush;
    logic        o_con_mdstart, o_con_mdbusy;
    logic [31:0] o_data_stallcnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    hazard_ctrl #(.MD_MUL_CYC(4), .MD_DIV_CYC(32), .REG_AW(5)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_addr_Drs         (i_addr_Drs),
        .i_addr_Drt         (i_addr_Drt),
        .i_con_Dusesrs      (i_con_Dusesrs),
        .i_con_Dusesrt      (i_con_Dusesrt),
        .i_addr_Eregdst     (i_addr_Eregdst),
        .i_con_Ememread     (i_con_Ememread),
        .i_con_Dmdstart     (i_con_Dmdstart),
        .i_con_Dmdkind      (i_con_Dmdkind),
        .i_con_Dmdread      (i_con_Dmdread),
        .i_con_Ebranchtaken (i_con_Ebranchtaken),
        .o_con_Fstall       (o_con_Fstall),
        .o_con_Dstall       (o_con_Dstall),
        .o_con_Dflush       (o_con_Dflush),
        .o_con_Eflush       (o_con_Eflush),
        .o_con_mdstart      (o_con_mdstart),
        .o_con_mdbusy       (o_con_mdbusy),
        .o_data_stallcnt    (o_data_stallcnt)
    );

    // exp = {Fstall, Dstall, Dflush, Eflush, mdstart, mdbusy}
    typedef struct {
        string      name;
        logic [4:0] drs, drt;
        logic       urs, urt;
        logic [4:0] ereg;
        logic       mem, mds, mdk, mdr, br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [5:0] outs();
        return {o_con_Fstall, o_con_Dstall, o_con_Dflush, o_con_Eflush, o_con_mdstart, o_con_mdbusy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        i_addr_Drs = v.drs; i_addr_Drt = v.drt;
        i_con_Dusesrs = v.urs; i_con_Dusesrt = v.urt;
        i_addr_Eregdst = v.ereg; i_con_Ememread = v.mem;
        i_con_Dmdstart = v.mds; i_con_Dmdkind = v.mdk;
        i_con_Dmdread = v.mdr; i_con_Ebranchtaken = v.br;
    endtask

    task automatic clear_inputs();
        i_addr_Drs = '0; i_addr_Drt = '0; i_addr_Eregdst = '0;
        i_con_Dusesrs = 1'b0; i_con_Dusesrt = 1'b0; i_con_Ememread = 1'b0;
        i_con_Dmdstart = 1'b0; i_con_Dmdkind = 1'b0; i_con_Dmdread = 1'b0;
        i_con_Ebranchtaken = 1'b0;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{"lu_rs",        5'd3, 5'd7, 1, 1, 5'd3, 1, 0, 0, 0, 0, 6'b110100};
        vecs[1] = '{"lu_zero_reg",  5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0, 6'b000000};
        vecs[2] = '{"lu_rt",        5'd9, 5'd3, 1, 1, 5'd3, 1, 0, 0, 0, 0, 6'b110100};
        vecs[3] = '{"rt_unused",    5'd9, 5'd3, 1, 0, 5'd3, 1, 0, 0, 0, 0, 6'b000000};
        vecs[4] = '{"no_load",      5'd3, 5'd3, 1, 1, 5'd3, 0, 0, 0, 0, 0, 6'b000000};
        vecs[5] = '{"lu_and_br",    5'd3, 5'd7, 1, 1, 5'd3, 1, 0, 0, 0, 1, 6'b001100};
        vecs[6] = '{"br_squash_md", 5'd3, 5'd7, 1, 1, 5'd3, 1, 1, 0, 0, 1, 6'b001100};
        vecs[7] = '{"lu_blocks_md", 5'd3, 5'd7, 1, 1, 5'd3, 1, 1, 0, 0, 0, 6'b110100};
        vecs[8] = '{"mfhi_idle",    5'd0, 5'd0, 0, 0, 5'd4, 0, 0, 0, 1, 0, 6'b000000};
        vecs[9] = '{"br_only",      5'd1, 5'd2, 1, 1, 5'd6, 0, 0, 0, 0, 1, 6'b001100};

        // Reset with a live load-use pattern on the inputs: every output must still be 0.
        i_rst = 1'b1;
        drive(vecs[0]);
        #12;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_stallcnt", o_data_stallcnt, 32'd0);
        @(negedge i_clk);
        clear_inputs();
        i_rst = 1'b0;

        // Single-cycle combinational hazards, each held across exactly one rising edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            drive(vecs[i]);
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // Multiply issue then mfhi immediately behind it: 4 stall cycles.
        @(negedge i_clk);
        clear_inputs();
        i_con_Dmdstart = 1'b1;
        i_con_Dmdkind = 1'b0;
        #1;
        check("mul_issue", 32'(outs()), 32'b000010);
        @(negedge i_clk);
        i_con_Dmdstart = 1'b0;
        i_con_Dmdread = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("mfhi_stall", 32'(outs()), 32'b110101);
            @(negedge i_clk);
        end
        #1;
        check("mfhi_release", 32'(outs()), 32'b000000);
`ifdef HAZARD_STALLCNT_EN
        check("stallcnt", o_data_stallcnt, 32'd7);
`else
        check("stallcnt", o_data_stallcnt, 32'd0);
`endif

        // Divide followed by a second divide held in D.
        @(negedge i_clk);
        clear_inputs();
        i_con_Dmdstart = 1'b1;
        i_con_Dmdkind = 1'b1;
        #1;
        check("div1_issue", 32'(outs()), 32'b000010);
        for (int k = 0; k < 32; k++) begin
            @(negedge i_clk);
            #1;
            check("div2_stall", 32'(outs()), 32'b110101);
        end
        @(negedge i_clk);
        #1;
        check("div2_issue", 32'(outs()), 32'b000010);
        @(negedge i_clk);
        clear_inputs();
        #1;
        check("div2_busy", 32'(outs()), 32'b000001);
        // Branch during RUN flushes but does not abort the op.
        i_con_Ebranchtaken = 1'b1;
        #1;
        check("br_in_run", 32'(outs()), 32'b001101);
        i_con_Ebranchtaken = 1'b0;

        // Advance to mid-divide, then an asynchronous reset pulse away from any edge.
        repeat (20) @(negedge i_clk);
        i_con_Dmdread = 1'b1;
        #1;
        check("mid_div_stall", 32'(outs()), 32'b110101);
        #1;
        i_rst = 1'b1;
        #1;
        check("async_rst_outs", 32'(outs()), 32'd0);
        check("async_rst_cnt", o_data_stallcnt, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("post_rst_mfhi", 32'(outs()), 32'b000000);
        @(negedge i_clk);
        #1;
        check("post_rst_idle", 32'(outs()), 32'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
